// File: rtl/vault_pkg.sv
// Shared types, the absolute encoder code table and decode helpers for the
// rotary front-end of the vault.
package vault_pkg;

  localparam int NUM_POS = 24;

  typedef logic [4:0] pos_t;

  typedef struct packed {
    logic valid;
    pos_t pos;
  } decode_t;

  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_CW,
    MOVE_CCW,
    MOVE_JUMP
  } move_t;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } track_state_t;

  // Index is the dial position; codes are unique, so at most one entry matches.
  localparam logic [7:0] ENC_CODE [0:NUM_POS-1] = '{
    8'h7F, 8'h38, 8'h08, 8'h4F, 8'hBF, 8'h1C, 8'h04, 8'hA7,
    8'hDF, 8'h0E, 8'h02, 8'hD3, 8'hEF, 8'h07, 8'h01, 8'hE9,
    8'hF7, 8'h83, 8'h80, 8'hF4, 8'hFB, 8'hC1, 8'h40, 8'h7A
  };

  function automatic decode_t decode_code(input logic [7:0] code);
    decode_t res;
    res.valid = 1'b0;
    res.pos   = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (ENC_CODE[i] == code) begin
        res.valid = 1'b1;
        res.pos   = pos_t'(i);
      end
    end
    return res;
  endfunction

  // Distance (to - from) mod 24, reduced to the kind of move it represents.
  function automatic move_t classify_move(input pos_t to_pos, input pos_t from_pos);
    logic [5:0] diff;
    diff = {1'b0, to_pos} + 6'd24 - {1'b0, from_pos};
    if (diff >= 6'd24) diff = diff - 6'd24;
    if (diff == 6'd0)       return MOVE_NONE;
    else if (diff == 6'd1)  return MOVE_CW;
    else if (diff == 6'd23) return MOVE_CCW;
    else                    return MOVE_JUMP;
  endfunction

endpackage

// File: rtl/encoder_sync_filter.sv
// Two-flop synchroniser for the raw encoder code followed by a stability
// filter that only flags a candidate after STABLE_CYCLES identical samples.
module encoder_sync_filter #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] re_in,
  output logic [7:0] cand,
  output logic       stable
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [3:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      cnt  <= '0;
    end else begin
      s1 <= re_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= 4'd1;
      end else if (cnt < STABLE_N) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign stable = (cnt == STABLE_N);

endmodule

// File: rtl/rotary_step_tracker.sv
// Turns the filtered encoder candidate into a dial position, single-cycle
// step/direction events and saturating direction-run bookkeeping.
module rotary_step_tracker
  import vault_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int RUN_W         = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       re_in,
  output logic [4:0]       position,
  output logic             pos_valid,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             step_err,
  output logic             bad_code,
  output logic             dir,
  output logic [RUN_W-1:0] run_len,
  output logic             dir_change,
  output logic [RUN_W-1:0] last_run
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [7:0]       cand;
  logic             stable;
  decode_t          dec;
  move_t            move;
  logic [RUN_W-1:0] run_inc;
  track_state_t     state;

  encoder_sync_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clock (clock),
    .reset (reset),
    .re_in (re_in),
    .cand  (cand),
    .stable(stable)
  );

  assign dec     = decode_code(cand);
  assign move    = classify_move(dec.pos, position);
  assign run_inc = (run_len == RUN_MAX) ? run_len : run_len + RUN_ONE;

  // Once position follows an accepted code, the move reads as MOVE_NONE,
  // so each accepted change fires exactly one event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      position   <= '0;
      pos_valid  <= 1'b0;
      step_cw    <= 1'b0;
      step_ccw   <= 1'b0;
      step_err   <= 1'b0;
      bad_code   <= 1'b0;
      dir        <= 1'b0;
      run_len    <= '0;
      dir_change <= 1'b0;
      last_run   <= '0;
    end else begin
      step_cw    <= 1'b0;
      step_ccw   <= 1'b0;
      step_err   <= 1'b0;
      dir_change <= 1'b0;
      bad_code   <= stable && !dec.valid;
      case (state)
        ST_INIT: begin
          if (stable && dec.valid) begin
            position  <= dec.pos;
            pos_valid <= 1'b1;
            state     <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (stable && dec.valid) begin
            case (move)
              MOVE_CW: begin
                step_cw  <= 1'b1;
                position <= dec.pos;
                dir      <= 1'b1;
                if (run_len == '0 || dir) begin
                  run_len <= run_inc;
                end else begin
                  dir_change <= 1'b1;
                  last_run   <= run_len;
                  run_len    <= RUN_ONE;
                end
              end
              MOVE_CCW: begin
                step_ccw <= 1'b1;
                position <= dec.pos;
                dir      <= 1'b0;
                if (run_len == '0 || !dir) begin
                  run_len <= run_inc;
                end else begin
                  dir_change <= 1'b1;
                  last_run   <= run_len;
                  run_len    <= RUN_ONE;
                end
              end
              MOVE_JUMP: begin
                step_err <= 1'b1;
                position <= dec.pos;
                run_len  <= '0;
              end
              default: ;
            endcase
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_step_tracker.sv
// Directed bench for rotary_step_tracker: acquisition latency, cw/ccw walks,
// glitch rejection, wrap-around, jumps, bad codes, run saturation and reset.
module tb_rotary_step_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] re_in = 8'h7F;
  logic [4:0] position;
  logic       pos_valid, step_cw, step_ccw, step_err, bad_code, dir, dir_change;
  logic [5:0] run_len, last_run;

  int n_asserts = 0;
  int n_fail    = 0;
  int cw_seen   = 0;
  int ccw_seen  = 0;
  int err_seen  = 0;
  int chg_seen  = 0;
  int both_seen = 0;

  logic [7:0] enc_codes [0:23] = '{
    8'h7F, 8'h38, 8'h08, 8'h4F, 8'hBF, 8'h1C, 8'h04, 8'hA7,
    8'hDF, 8'h0E, 8'h02, 8'hD3, 8'hEF, 8'h07, 8'h01, 8'hE9,
    8'hF7, 8'h83, 8'h80, 8'hF4, 8'hFB, 8'hC1, 8'h40, 8'h7A
  };

  rotary_step_tracker #(
    .STABLE_CYCLES(2),
    .RUN_W(6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .re_in     (re_in),
    .position  (position),
    .pos_valid (pos_valid),
    .step_cw   (step_cw),
    .step_ccw  (step_ccw),
    .step_err  (step_err),
    .bad_code  (bad_code),
    .dir       (dir),
    .run_len   (run_len),
    .dir_change(dir_change),
    .last_run  (last_run)
  );

  always #10 clock = ~clock;

  // Pulse tally; a pulse stretched past one cycle is counted twice.
  always @(negedge clock) begin
    if (step_cw)    cw_seen++;
    if (step_ccw)   ccw_seen++;
    if (step_err)   err_seen++;
    if (dir_change) chg_seen++;
    if (dir_change && (step_cw || step_ccw)) both_seen++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] code, input int hold);
    re_in = code;
    repeat (hold) @(negedge clock);
  endtask

  task automatic check_output(input string tag, input int pos, input int run,
                              input int d, input int cw, input int ccw,
                              input int err, input int chg);
    check({tag, "/position"}, int'(position), pos);
    check({tag, "/run_len"}, int'(run_len), run);
    check({tag, "/dir"}, int'(dir), d);
    check({tag, "/cw_count"}, cw_seen, cw);
    check({tag, "/ccw_count"}, ccw_seen, ccw);
    check({tag, "/err_count"}, err_seen, err);
    check({tag, "/chg_count"}, chg_seen, chg);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset/pos_valid", int'(pos_valid), 0);
    check("reset/bad_code", int'(bad_code), 0);
    check("reset/last_run", int'(last_run), 0);
    check_output("reset", 0, 0, 0, 0, 0, 0, 0);

    // First edge after release samples 7F; outputs move at edge k+4.
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("acq_early/pos_valid", int'(pos_valid), 0);
    @(negedge clock);
    check("acq/pos_valid", int'(pos_valid), 1);
    @(negedge clock);
    check_output("acq", 0, 0, 0, 0, 0, 0, 0);

    apply_stimulus(8'h38, 6);
    apply_stimulus(8'h08, 6);
    apply_stimulus(8'h4F, 6);
    check_output("walk3", 3, 3, 1, 3, 0, 0, 0);
    check("walk3/step_cw_idle", int'(step_cw), 0);

    apply_stimulus(8'hBF, 6);
    apply_stimulus(8'h1C, 6);
    apply_stimulus(8'h04, 6);
    apply_stimulus(8'hA7, 6);
    check_output("walk7", 7, 7, 1, 7, 0, 0, 0);

    apply_stimulus(8'h04, 1);
    apply_stimulus(8'hA7, 6);
    check_output("glitch", 7, 7, 1, 7, 0, 0, 0);

    apply_stimulus(8'h04, 6);
    check_output("rev1", 6, 1, 0, 7, 1, 0, 1);
    check("rev1/last_run", int'(last_run), 7);
    check("rev1/coincident", both_seen, 1);
    apply_stimulus(8'h1C, 6);
    check_output("rev2", 5, 2, 0, 7, 2, 0, 1);
    check("rev2/last_run", int'(last_run), 7);

    apply_stimulus(8'h7A, 6);
    check_output("jump23", 23, 0, 0, 7, 2, 1, 1);
    apply_stimulus(8'h7F, 6);
    check_output("wrap_cw", 0, 1, 1, 8, 2, 1, 1);
    apply_stimulus(8'h7A, 6);
    check_output("wrap_ccw", 23, 1, 0, 8, 3, 1, 2);
    check("wrap_ccw/last_run", int'(last_run), 1);

    apply_stimulus(8'h7F, 6);
    apply_stimulus(8'h38, 6);
    apply_stimulus(8'h08, 6);
    check_output("to2", 2, 3, 1, 11, 3, 1, 3);
    apply_stimulus(8'hBF, 6);
    check_output("jump4", 4, 0, 1, 11, 3, 2, 3);

    apply_stimulus(8'h55, 6);
    check("bad/bad_code", int'(bad_code), 1);
    check("bad/pos_valid", int'(pos_valid), 1);
    check_output("bad", 4, 0, 1, 11, 3, 2, 3);
    apply_stimulus(8'hBF, 6);
    check("bad_clear/bad_code", int'(bad_code), 0);
    check_output("bad_clear", 4, 0, 1, 11, 3, 2, 3);

    for (int i = 1; i <= 66; i++) apply_stimulus(enc_codes[(4 + i) % 24], 6);
    check_output("saturate", 22, 63, 1, 77, 3, 2, 3);
    apply_stimulus(8'hC1, 6);
    check_output("sat_rev", 21, 1, 0, 77, 4, 2, 4);
    check("sat_rev/last_run", int'(last_run), 63);

    // Reset lands mid-cycle, between clock edges, to prove it is asynchronous.
    @(posedge clock);
    #5 reset = 1'b1;
    #1;
    check("mid_reset/position", int'(position), 0);
    check("mid_reset/pos_valid", int'(pos_valid), 0);
    check("mid_reset/run_len", int'(run_len), 0);
    check("mid_reset/last_run", int'(last_run), 0);
    check("mid_reset/pulses", int'({step_cw, step_ccw, step_err, dir_change, bad_code, dir}), 0);
    #9 reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("reacq_early/pos_valid", int'(pos_valid), 0);
    @(posedge clock);
    #1;
    check("reacq/pos_valid", int'(pos_valid), 1);
    check("reacq/bad_code", int'(bad_code), 0);
    repeat (2) @(negedge clock);
    check_output("reacq", 21, 0, 0, 77, 4, 2, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
